// File: rtl/eth_rx_dispatch_pkg.sv
// Shared types and constants for the RMII receive dispatch path.
package eth_rx_pkg;

  localparam int MAC_BITS   = 48;
  localparam int ETYPE_BITS = 16;
  localparam logic [MAC_BITS-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    SRC,
    ETYPE,
    PAYLOAD,
    DROP
  } rx_state_t;

  typedef enum logic [1:0] {
    ST_IPV4 = 2'd0,
    ST_ARP  = 2'd1,
    ST_FILT = 2'd2,
    ST_RUNT = 2'd3
  } frame_status_t;

endpackage

// File: rtl/eth_rx_dispatch_mac_filter.sv
// Destination MAC acceptance check: unicast to this station or broadcast.
// Kept standalone so the TX loopback check can reuse it.
module mac_filter
  import eth_rx_pkg::*;
#(
  parameter logic [MAC_BITS-1:0] MY_MAC = '0
) (
  input  logic [MAC_BITS-1:0] dst_i,
  output logic                match_o
);

  assign match_o = (dst_i == MY_MAC) || (dst_i == BCAST_MAC);

endmodule

// File: rtl/eth_rx_dispatch.sv
// Frame-level receive sequencer: header tracking, dst MAC filter, ethertype
// classifier handshake, payload steering, per-frame status and drop count.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | between frames; first valid beat is dst beat 0
//  DST     | shifting in the destination MAC
//  SRC     | skipping the source MAC
//  ETYPE   | ethertype beats forwarded to the external classifier
//  PAYLOAD | payload beats registered to the IPv4 or ARP consumer
//  DROP    | filtered/unknown frame, or partial frame seen after reset
module eth_rx_dispatch
  import eth_rx_pkg::*;
#(
  parameter int                  N      = 2,
  parameter logic [MAC_BITS-1:0] MY_MAC = '0,
  parameter int                  CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     axiid,
  input  logic             axiiv,
  output logic [N-1:0]     etype_axiid,
  output logic             etype_axiiv,
  input  logic             etype_axiov,
  input  logic             etype_axiod,
  output logic [N-1:0]     ipv4_axiod,
  output logic             ipv4_axiov,
  output logic [N-1:0]     arp_axiod,
  output logic             arp_axiov,
  output logic             frame_done,
  output logic [1:0]       frame_status,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int MAC_BEATS   = MAC_BITS / N;
  localparam int ETYPE_BEATS = ETYPE_BITS / N;
  localparam int CNT_BITS    = $clog2(MAC_BEATS) + 1;
  // dst beat 0 is consumed in IDLE, so DST itself only sees MAC_BEATS-1 beats
  localparam logic [CNT_BITS-1:0] DST_LAST   = CNT_BITS'(MAC_BEATS - 2);
  localparam logic [CNT_BITS-1:0] SRC_LAST   = CNT_BITS'(MAC_BEATS - 1);
  localparam logic [CNT_BITS-1:0] ETYPE_LAST = CNT_BITS'(ETYPE_BEATS - 1);

  rx_state_t             state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [MAC_BITS-N-1:0] dst_sr_q, dst_sr_d;
  frame_status_t         status_q, status_d;
  frame_status_t         fstat_q, fstat_d;
  logic                  resync_q, resync_d;
  logic [N-1:0]          ipv4_axiod_q, ipv4_axiod_d, arp_axiod_q, arp_axiod_d;
  logic                  ipv4_axiov_q, ipv4_axiov_d, arp_axiov_q, arp_axiov_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic                  mac_match;

  mac_filter #(.MY_MAC(MY_MAC)) u_mac_filter (
    .dst_i   ({dst_sr_q, axiid}),
    .match_o (mac_match)
  );

  // State and output registers; resync starts set so a frame already in
  // flight at reset release is swallowed without a status report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dst_sr_q     <= '0;
      status_q     <= ST_IPV4;
      fstat_q      <= ST_IPV4;
      resync_q     <= 1'b1;
      ipv4_axiod_q <= '0;
      ipv4_axiov_q <= 1'b0;
      arp_axiod_q  <= '0;
      arp_axiov_q  <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dst_sr_q     <= dst_sr_d;
      status_q     <= status_d;
      fstat_q      <= fstat_d;
      resync_q     <= resync_d;
      ipv4_axiod_q <= ipv4_axiod_d;
      ipv4_axiov_q <= ipv4_axiov_d;
      arp_axiod_q  <= arp_axiod_d;
      arp_axiov_q  <= arp_axiov_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
    end
  end

  // Next-state, header bookkeeping, payload steering and end-of-frame status.
  always_comb begin
    frame_status_t end_st;
    state_d      = state_q;
    cnt_d        = cnt_q;
    dst_sr_d     = dst_sr_q;
    status_d     = status_q;
    fstat_d      = fstat_q;
    resync_d     = resync_q;
    ipv4_axiod_d = '0;
    ipv4_axiov_d = 1'b0;
    arp_axiod_d  = '0;
    arp_axiov_d  = 1'b0;
    done_d       = 1'b0;
    drop_d       = drop_q;
    end_st       = status_q;

    if (!axiiv) begin
      resync_d = 1'b0;
      state_d  = IDLE;
      cnt_d    = '0;
      if (state_q != IDLE && !(state_q == DROP && resync_q)) begin
        if (state_q inside {DST, SRC, ETYPE}) end_st = ST_RUNT;
        done_d  = 1'b1;
        fstat_d = end_st;
        if ((end_st == ST_FILT || end_st == ST_RUNT) && drop_q != '1)
          drop_d = drop_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_d    = '0;
          dst_sr_d = {dst_sr_q[MAC_BITS-2*N-1:0], axiid};
          state_d  = resync_q ? DROP : DST;
        end
        DST: begin
          dst_sr_d = {dst_sr_q[MAC_BITS-2*N-1:0], axiid};
          if (cnt_q == DST_LAST) begin
            cnt_d = '0;
            if (mac_match) begin
              state_d = SRC;
            end else begin
              state_d  = DROP;
              status_d = ST_FILT;
            end
          end
        end
        SRC: begin
          if (cnt_q == SRC_LAST) begin
            cnt_d   = '0;
            state_d = ETYPE;
          end
        end
        ETYPE: begin
          if (cnt_q == ETYPE_LAST) begin
            cnt_d = '0;
            if (etype_axiov) begin
              state_d  = PAYLOAD;
              status_d = etype_axiod ? ST_ARP : ST_IPV4;
            end else begin
              state_d  = DROP;
              status_d = ST_FILT;
            end
          end
        end
        PAYLOAD: begin
          cnt_d = '0;
          if (status_q == ST_ARP) begin
            arp_axiod_d = axiid;
            arp_axiov_d = 1'b1;
          end else begin
            ipv4_axiod_d = axiid;
            ipv4_axiov_d = 1'b1;
          end
        end
        DROP: cnt_d = '0;
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign etype_axiid  = axiid;
  assign etype_axiiv  = axiiv && (state_q == ETYPE);
  assign ipv4_axiod   = ipv4_axiod_q;
  assign ipv4_axiov   = ipv4_axiov_q;
  assign arp_axiod    = arp_axiod_q;
  assign arp_axiov    = arp_axiov_q;
  assign frame_done   = done_q;
  assign frame_status = fstat_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Bench for eth_rx_dispatch with a behavioural ethertype classifier (IPv4/ARP).
module tb_eth_rx_dispatch;

  localparam int          N   = 2;
  localparam logic [47:0] MY  = 48'h0242_AC11_0002;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
  localparam int          HDR = 56;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  axiid = '0;
  logic        axiiv = 1'b0;
  logic [1:0]  etype_axiid;
  logic        etype_axiiv;
  logic        etype_axiov;
  logic        etype_axiod;
  logic [1:0]  ipv4_axiod;
  logic        ipv4_axiov;
  logic [1:0]  arp_axiod;
  logic        arp_axiov;
  logic        frame_done;
  logic [1:0]  frame_status;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  eth_rx_dispatch #(.N(N), .MY_MAC(MY), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .axiid        (axiid),
    .axiiv        (axiiv),
    .etype_axiid  (etype_axiid),
    .etype_axiiv  (etype_axiiv),
    .etype_axiov  (etype_axiov),
    .etype_axiod  (etype_axiod),
    .ipv4_axiod   (ipv4_axiod),
    .ipv4_axiov   (ipv4_axiov),
    .arp_axiod    (arp_axiod),
    .arp_axiov    (arp_axiov),
    .frame_done   (frame_done),
    .frame_status (frame_status),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ethertype classifier: counts etype beats, verdict on the 8th beat.
  logic [3:0]  ecnt = '0;
  logic [13:0] esr  = '0;
  logic [15:0] efull;
  assign efull = {esr, etype_axiid};
  always @(posedge clk) begin
    if (!etype_axiiv) begin
      ecnt <= '0;
      esr  <= '0;
    end else begin
      ecnt <= ecnt + 4'd1;
      esr  <= {esr[11:0], etype_axiid};
    end
  end
  assign etype_axiov = etype_axiiv && (ecnt == 4'd7) && (efull == 16'h0800 || efull == 16'h0806);
  assign etype_axiod = etype_axiiv && (ecnt == 4'd7) && (efull == 16'h0806);

  // Monitor
  logic [1:0] got_ipv4[$];
  logic [1:0] got_arp[$];
  int got_st[$];
  int got_done_cyc[$];
  int got_drop[$];
  int etype_beats, both_hi, first_out_cyc;

  always @(negedge clk) begin
    if (ipv4_axiov) begin
      got_ipv4.push_back(ipv4_axiod);
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    if (arp_axiov) begin
      got_arp.push_back(arp_axiod);
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    if (ipv4_axiov && arp_axiov) both_hi++;
    if (frame_done) begin
      got_st.push_back(int'(frame_status));
      got_done_cyc.push_back(cyc);
      got_drop.push_back(int'(drop_cnt));
    end
    if (etype_axiiv) etype_beats++;
  end

  task automatic clear_mon();
    got_ipv4.delete(); got_arp.delete(); got_st.delete();
    got_done_cyc.delete(); got_drop.delete();
    etype_beats = 0; both_hi = 0; first_out_cyc = -1;
  endtask

  // Frame builder and driver
  logic [1:0] fq[$];
  logic [1:0] exp_pl[$];
  int drv_pl_cyc, off_cyc;

  task automatic push_byte(input logic [7:0] b, input bit is_pl);
    for (int k = 3; k >= 0; k--) begin
      fq.push_back(b[2*k+1 -: 2]);
      if (is_pl) exp_pl.push_back(b[2*k+1 -: 2]);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input int nbytes);
    fq.delete(); exp_pl.delete();
    for (int i = 0; i < 6; i++) push_byte(dst[47-8*i -: 8], 1'b0);
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)), 1'b0);
    push_byte(et[15:8], 1'b0);
    push_byte(et[7:0], 1'b0);
    for (int i = 0; i < nbytes; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic send(input int nbeats, input int idle_n);
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      axiid = fq[i];
      axiiv = 1'b1;
      if (i == HDR) drv_pl_cyc = cyc;
    end
    @(posedge clk); #1;
    axiiv = 1'b0;
    axiid = '0;
    off_cyc = cyc;
    repeat (idle_n - 1) @(posedge clk);
  endtask

  // Reference model from the frame rules
  function automatic int exp_status(input logic [47:0] dst, input logic [15:0] et, input int nb);
    if (nb < 24) return 3;
    if (!(dst == MY || dst == BC)) return 2;
    if (nb < HDR) return 3;
    if (et == 16'h0800) return 0;
    if (et == 16'h0806) return 1;
    return 2;
  endfunction

  function automatic int exp_ebeats(input logic [47:0] dst, input int nb);
    if (nb < 24 || !(dst == MY || dst == BC)) return 0;
    if (nb <= 48) return 0;
    if (nb >= HDR) return 8;
    return nb - 48;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    axiiv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ipv4_axiov, arp_axiov, frame_done, etype_axiiv} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b required 0000", {ipv4_axiov, arp_axiov, frame_done, etype_axiiv});
    end
    n_checks++;
    if (drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt);
    end
    n_checks++;
    if ({ipv4_axiod, arp_axiod, frame_status} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %b required 000000", {ipv4_axiod, arp_axiod, frame_status});
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_arp_bcast();
    bit ok;
    build(BC, 16'h0806, 10);
    clear_mon();
    send(fq.size(), 4);
    ok = (got_arp.size() == exp_pl.size());
    for (int i = 0; i < got_arp.size() && ok; i++) if (got_arp[i] !== exp_pl[i]) ok = 0;
    n_checks++;
    if (!ok || got_arp.size() != 40) begin
      n_fail++;
      $display("FAIL arp_data: got %0d beats required 40 matching", got_arp.size());
    end
    n_checks++;
    if (got_ipv4.size() != 0) begin
      n_fail++;
      $display("FAIL arp_no_ipv4: got %0d ipv4 beats required 0", got_ipv4.size());
    end
    n_checks++;
    if (first_out_cyc - drv_pl_cyc != 1) begin
      n_fail++;
      $display("FAIL arp_latency: got %0d cycles required 1", first_out_cyc - drv_pl_cyc);
    end
    n_checks++;
    if (got_st.size() != 1 || got_st[0] != 1) begin
      n_fail++;
      $display("FAIL arp_status: got %0d done, status %0d required 1 done status 1", got_st.size(), got_st.size() ? got_st[0] : -1);
    end
  endtask

  task automatic test_ipv4_mine();
    bit ok;
    build(MY, 16'h0800, 20);
    clear_mon();
    send(fq.size(), 4);
    ok = (got_ipv4.size() == exp_pl.size());
    for (int i = 0; i < got_ipv4.size() && ok; i++) if (got_ipv4[i] !== exp_pl[i]) ok = 0;
    n_checks++;
    if (!ok || got_ipv4.size() != 80 || got_arp.size() != 0) begin
      n_fail++;
      $display("FAIL ipv4_data: got %0d ipv4 %0d arp beats required 80 matching, 0", got_ipv4.size(), got_arp.size());
    end
    n_checks++;
    if (got_st.size() != 1 || got_st[0] != 0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL ipv4_status: got %0d done, status %0d, drop %0d required 1, 0, 0", got_st.size(), got_st.size() ? got_st[0] : -1, drop_cnt);
    end
    n_checks++;
    if (etype_beats != 8) begin
      n_fail++;
      $display("FAIL ipv4_etype_beats: got %0d required 8", etype_beats);
    end
  endtask

  task automatic test_filtered_dst();
    build(48'h0242_AC11_0003, 16'h0800, 10);
    clear_mon();
    send(fq.size(), 4);
    n_checks++;
    if (got_st.size() != 1 || got_st[0] != 2 || drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL filt_status: got %0d done, status %0d, drop %0d required 1, 2, 1", got_st.size(), got_st.size() ? got_st[0] : -1, drop_cnt);
    end
    n_checks++;
    if (etype_beats != 0 || got_ipv4.size() != 0 || got_arp.size() != 0) begin
      n_fail++;
      $display("FAIL filt_quiet: got etype %0d ipv4 %0d arp %0d required 0 0 0", etype_beats, got_ipv4.size(), got_arp.size());
    end
  endtask

  task automatic test_unknown_etype();
    build(MY, 16'h86DD, 10);
    clear_mon();
    send(fq.size(), 4);
    n_checks++;
    if (got_st.size() != 1 || got_st[0] != 2 || drop_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL etype_status: got %0d done, status %0d, drop %0d required 1, 2, 2", got_st.size(), got_st.size() ? got_st[0] : -1, drop_cnt);
    end
    n_checks++;
    if (got_ipv4.size() != 0 || got_arp.size() != 0) begin
      n_fail++;
      $display("FAIL etype_no_payload: got ipv4 %0d arp %0d required 0 0", got_ipv4.size(), got_arp.size());
    end
  endtask

  task automatic test_runt_back_to_back();
    int off1;
    bit ok;
    build(MY, 16'h0800, 8);
    clear_mon();
    send(30, 1);
    off1 = off_cyc;
    build(BC, 16'h0806, 8);
    send(fq.size(), 4);
    n_checks++;
    if (got_st.size() != 2 || got_st[0] != 3 || got_drop[0] != 3) begin
      n_fail++;
      $display("FAIL runt_status: got %0d done, status %0d, drop %0d required 2, 3, 3", got_st.size(), got_st.size() ? got_st[0] : -1, got_drop.size() ? got_drop[0] : -1);
    end
    n_checks++;
    if (got_done_cyc.size() == 0 || got_done_cyc[0] - off1 != 1) begin
      n_fail++;
      $display("FAIL runt_done_timing: got %0d cycles required 1", got_done_cyc.size() ? got_done_cyc[0] - off1 : -1);
    end
    ok = (got_arp.size() == exp_pl.size()) && (got_arp.size() == 32);
    for (int i = 0; i < got_arp.size() && ok; i++) if (got_arp[i] !== exp_pl[i]) ok = 0;
    n_checks++;
    if (!ok || got_st.size() != 2 || got_st[1] != 1 || drop_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL b2b_frame: got %0d arp beats, status %0d, drop %0d required 32, 1, 3", got_arp.size(), got_st.size() > 1 ? got_st[1] : -1, drop_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    build(MY, 16'h0800, 20);
    clear_mon();
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      axiid = fq[i];
      axiiv = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    axiid = fq[70];
    #1;
    n_checks++;
    if ({ipv4_axiov, ipv4_axiod, frame_done} !== 4'b0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_async: got v%b d%b done%b drop %0d required all 0", ipv4_axiov, ipv4_axiod, frame_done, drop_cnt);
    end
    clear_mon();
    for (int i = 71; i < 73; i++) begin
      @(posedge clk); #1;
      axiid = fq[i];
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 73; i < fq.size(); i++) begin
      axiid = fq[i];
      @(posedge clk); #1;
    end
    axiiv = 1'b0;
    axiid = '0;
    repeat (4) @(posedge clk);
    n_checks++;
    if (got_st.size() != 0 || got_ipv4.size() != 0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_partial: got %0d done %0d ipv4 drop %0d required 0 0 0", got_st.size(), got_ipv4.size(), drop_cnt);
    end
    build(BC, 16'h0806, 10);
    clear_mon();
    send(fq.size(), 4);
    ok = (got_arp.size() == exp_pl.size()) && (got_arp.size() == 40);
    for (int i = 0; i < got_arp.size() && ok; i++) if (got_arp[i] !== exp_pl[i]) ok = 0;
    n_checks++;
    if (!ok || got_st.size() != 1 || got_st[0] != 1 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_recover: got %0d arp beats, %0d done, drop %0d required 40, status 1, 0", got_arp.size(), got_st.size(), drop_cnt);
    end
  endtask

  task automatic test_random();
    logic [47:0] dst;
    logic [15:0] et;
    int nb, st, npl, exp_drop;
    bit ok;
    exp_drop = 0;
    for (int f = 0; f < 16; f++) begin
      case ($urandom_range(0, 2))
        0: dst = MY;
        1: dst = BC;
        default: dst = {16'($urandom), 32'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0: et = 16'h0800;
        1: et = 16'h0806;
        2: et = 16'h86DD;
        default: et = 16'($urandom);
      endcase
      build(dst, et, $urandom_range(0, 12));
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, fq.size()) : fq.size();
      st = exp_status(dst, et, nb);
      npl = (st < 2) ? nb - HDR : 0;
      if (st >= 2) exp_drop++;
      clear_mon();
      send(nb, $urandom_range(2, 4));
      repeat (2) @(posedge clk);
      n_checks++;
      if (got_st.size() != 1 || got_st[0] != st || drop_cnt !== 16'(exp_drop)) begin
        n_fail++;
        $display("FAIL rnd_status[%0d]: got %0d done status %0d drop %0d required status %0d drop %0d", f, got_st.size(), got_st.size() ? got_st[0] : -1, drop_cnt, st, exp_drop);
      end
      ok = (st == 1) ? (got_arp.size() == npl && got_ipv4.size() == 0)
                     : (got_ipv4.size() == npl && got_arp.size() == 0);
      for (int i = 0; i < npl && ok; i++)
        if (((st == 1) ? got_arp[i] : got_ipv4[i]) !== exp_pl[i]) ok = 0;
      n_checks++;
      if (!ok || both_hi != 0) begin
        n_fail++;
        $display("FAIL rnd_payload[%0d]: got ipv4 %0d arp %0d both %0d required %0d beats on class %0d", f, got_ipv4.size(), got_arp.size(), both_hi, npl, st);
      end
      n_checks++;
      if (etype_beats != exp_ebeats(dst, nb)) begin
        n_fail++;
        $display("FAIL rnd_etype_beats[%0d]: got %0d required %0d", f, etype_beats, exp_ebeats(dst, nb));
      end
    end
  endtask

  initial begin
    clear_mon();
    drv_pl_cyc = 0;
    off_cyc = 0;
    test_reset();
    test_arp_bcast();
    test_ipv4_mine();
    test_filtered_dst();
    test_unknown_etype();
    test_runt_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
